// File: rtl/cache_pkg.sv
// Shared constants and FSM state type for the cache miss controller.
// WAYS/SETS/TAG_BITS are fixed by the tag store this controller drives.
package cache_pkg;
  localparam int WAYS       = 8;
  localparam int WAY_BITS   = 3;
  localparam int SETS       = 8;
  localparam int INDEX_BITS = 3;
  localparam int TAG_BITS   = 24;
  localparam int PLRU_BITS  = WAYS - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } state_t;
endpackage

// File: rtl/plru_tree8.sv
// Tree pseudo-LRU for one 8-way set (combinational).
//   state     : 7-bit tree, b[0] root, b[1..2] level 1, b[3..6] leaves;
//               a 1 bit points the victim into the upper half
//   acc_way   : way being touched
//   nxt_state : tree after touching acc_way
//   victim    : way the current tree points at
module plru_tree8
  import cache_pkg::*;
(
  input  logic [PLRU_BITS-1:0] state,
  input  logic [WAY_BITS-1:0]  acc_way,
  output logic [PLRU_BITS-1:0] nxt_state,
  output logic [WAY_BITS-1:0]  victim
);
  // Touch points every node on the path away from the accessed way.
  always_comb begin
    nxt_state = state;
    nxt_state[0] = ~acc_way[2];
    nxt_state[3'd1 + {2'b00, acc_way[2]}] = ~acc_way[1];
    nxt_state[3'd3 + {1'b0, acc_way[2:1]}] = ~acc_way[0];
  end

  logic v2, v1;
  always_comb begin
    v2 = state[0];
    v1 = state[3'd1 + {2'b00, v2}];
    victim = {v2, v1, state[3'd3 + {1'b0, v2, v1}]};
  end
endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss handling and replacement controller behind an 8-way tag store.
// Hits complete the cycle after the lookup and touch the set's PLRU; misses
// pick a victim (lowest invalid way, else PLRU), run a memory req/resp
// handshake, pulse replace for one fill cycle, then report completion.
//   clk, reset (async active-low)
//   req_*      : lookup from requester, req_ready high only in IDLE
//   hit/hit_way/valid_vec : tag store lookup results for cache_tag/index
//   cache_tag/cache_index/way/replace : tag store drive
//   mem_req_* / mem_resp_valid : refill handshake
//   resp_*     : one-cycle completion pulse
module cache_miss_ctrl
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic [INDEX_BITS-1:0] req_index,
  output logic                  req_ready,
  input  logic                  hit,
  input  logic [WAY_BITS-1:0]   hit_way,
  input  logic [WAYS-1:0]       valid_vec,
  output logic [TAG_BITS-1:0]   cache_tag,
  output logic [INDEX_BITS-1:0] cache_index,
  output logic [WAY_BITS-1:0]   way,
  output logic                  replace,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [TAG_BITS-1:0]   mem_req_tag,
  output logic [INDEX_BITS-1:0] mem_req_index,
  input  logic                  mem_resp_valid,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [WAY_BITS-1:0]   resp_way
);
  state_t state, nxt;

  logic [SETS-1:0][PLRU_BITS-1:0] plru;
  logic [TAG_BITS-1:0]   cap_tag;
  logic [INDEX_BITS-1:0] cap_index;
  logic [WAY_BITS-1:0]   cap_way;

  logic                  upd_en;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [WAY_BITS-1:0]   upd_way;
  logic [PLRU_BITS-1:0]  upd_state;
  logic [WAY_BITS-1:0]   plru_victim;
  logic [PLRU_BITS-1:0]  unused_upd;
  logic [WAY_BITS-1:0]   unused_vic;
  logic [WAY_BITS-1:0]   victim_sel;

  // Update tree: indexed by whichever set is being touched this cycle.
  plru_tree8 u_upd (
    .state     (plru[upd_idx]),
    .acc_way   (upd_way),
    .nxt_state (upd_state),
    .victim    (unused_vic)
  );

  // Victim tree: always looks at the set currently being looked up.
  plru_tree8 u_vic (
    .state     (plru[req_index]),
    .acc_way   (hit_way),
    .nxt_state (unused_upd),
    .victim    (plru_victim)
  );

  // Filling an empty way beats evicting; scan high-to-low so the lowest wins.
  always_comb begin
    victim_sel = plru_victim;
    for (int i = WAYS - 1; i >= 0; i--)
      if (!valid_vec[i]) victim_sel = WAY_BITS'(i);
  end

  always_comb begin
    nxt           = state;
    req_ready     = 1'b0;
    cache_tag     = cap_tag;
    cache_index   = cap_index;
    way           = '0;
    replace       = 1'b0;
    mem_req_valid = 1'b0;
    upd_en        = 1'b0;
    upd_idx       = req_index;
    upd_way       = hit_way;
    case (state)
      IDLE: begin
        req_ready   = 1'b1;
        cache_tag   = req_tag;
        cache_index = req_index;
        if (req_valid) begin
          if (hit) upd_en = 1'b1;
          else     nxt    = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) nxt = WAIT;
      end
      WAIT: if (mem_resp_valid) nxt = FILL;
      FILL: begin
        replace = 1'b1;
        way     = cap_way;
        upd_en  = 1'b1;
        upd_idx = cap_index;
        upd_way = cap_way;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign mem_req_tag   = cap_tag;
  assign mem_req_index = cap_index;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      plru       <= '0;
      cap_tag    <= '0;
      cap_index  <= '0;
      cap_way    <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_way   <= '0;
    end else begin
      state <= nxt;
      if (upd_en) plru[upd_idx] <= upd_state;
      if (state == IDLE && req_valid && !hit) begin
        cap_tag   <= req_tag;
        cap_index <= req_index;
        cap_way   <= victim_sel;
      end
      // Completion lands the cycle after the hit lookup or after the fill.
      resp_valid <= (state == IDLE && req_valid && hit) || state == FILL;
      resp_hit   <= (state == IDLE && req_valid && hit);
      resp_way   <= (state == FILL) ? cap_way : hit_way;
    end
  end
endmodule

// File: tb/tb_cache_miss_ctrl.sv
module tb_cache_miss_ctrl;
  import cache_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic                  req_ready;
  logic                  hit;
  logic [WAY_BITS-1:0]   hit_way;
  logic [WAYS-1:0]       valid_vec;
  logic [TAG_BITS-1:0]   cache_tag;
  logic [INDEX_BITS-1:0] cache_index;
  logic [WAY_BITS-1:0]   way;
  logic                  replace;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [TAG_BITS-1:0]   mem_req_tag;
  logic [INDEX_BITS-1:0] mem_req_index;
  logic                  mem_resp_valid;
  logic                  resp_valid;
  logic                  resp_hit;
  logic [WAY_BITS-1:0]   resp_way;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];   // {hit, way} expected per completion

  always #5 clk = ~clk;

  cache_miss_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_tag(req_tag), .req_index(req_index), .req_ready(req_ready),
    .hit(hit), .hit_way(hit_way), .valid_vec(valid_vec),
    .cache_tag(cache_tag), .cache_index(cache_index), .way(way), .replace(replace),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_tag(mem_req_tag), .mem_req_index(mem_req_index),
    .mem_resp_valid(mem_resp_valid),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way)
  );

  // Response monitor: every completion must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && resp_valid) begin
      logic [3:0] e;
      checks++;
      if (replace) begin
        errors++;
        $display("FAIL resp_in_replace: resp_valid=1 with replace=1");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got hit=%0b way=%0d, expected none", resp_hit, resp_way);
      end else begin
        e = sb.pop_front();
        if ({resp_hit, resp_way} !== e) begin
          errors++;
          $display("FAIL resp: got hit=%0b way=%0d, expected hit=%0b way=%0d",
                   resp_hit, resp_way, e[3], e[2:0]);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; req_valid = 0; req_tag = '0; req_index = '0; hit = 0; hit_way = '0;
    valid_vec = '0; mem_req_ready = 0; mem_resp_valid = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, replace, way, mem_req_valid, resp_valid, mem_req_tag, mem_req_index} !==
        {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 24'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_values: ready=%0b replace=%0b way=%0d mreq=%0b resp=%0b, expected 1 0 0 0 0",
               req_ready, replace, way, mem_req_valid, resp_valid);
    end
    reset = 1'b1;
  endtask

  task automatic touch(input logic [2:0] idx, input logic [2:0] w);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL hit_ready: req_ready=%0b expected 1", req_ready);
    end
    req_valid = 1; hit = 1; hit_way = w; req_index = idx; req_tag = 24'hAAAA00 | 24'(w);
    sb.push_back({1'b1, w});
    @(negedge clk);
    req_valid = 0; hit = 0;
  endtask

  // Full miss flow; abort asserts reset while in WAIT instead of responding.
  task automatic do_miss(input logic [23:0] tag, input logic [2:0] idx, input logic [7:0] vv,
                         input logic [2:0] exp_v, input int rdy_dly, input bit stray,
                         input bit abort);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL miss_ready: req_ready=%0b expected 1", req_ready);
    end
    req_valid = 1; req_tag = tag; req_index = idx; hit = 0; valid_vec = vv;
    if (!abort) sb.push_back({1'b0, exp_v});
    @(negedge clk);
    req_valid = 0;
    for (int i = 0; i <= rdy_dly; i++) begin
      checks++;
      if ({mem_req_valid, mem_req_tag, mem_req_index, req_ready} !== {1'b1, tag, idx, 1'b0}) begin
        errors++;
        $display("FAIL mem_req[%0d]: valid=%0b tag=%h idx=%0d ready=%0b, expected 1 %h %0d 0",
                 i, mem_req_valid, mem_req_tag, mem_req_index, req_ready, tag, idx);
      end
      if (i == rdy_dly) mem_req_ready = 1;
      else if (stray && i == 1) mem_resp_valid = 1;
      @(negedge clk);
      mem_resp_valid = 0;
    end
    mem_req_ready = 0;
    checks++;
    if ({mem_req_valid, replace} !== 2'b00) begin
      errors++;
      $display("FAIL wait_state: mem_req_valid=%0b replace=%0b expected 0 0", mem_req_valid, replace);
    end
    if (abort) begin
      reset = 1'b0;
      #1;
      checks++;
      if ({req_ready, replace, mem_req_valid, way} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
        errors++;
        $display("FAIL reset_in_wait: ready=%0b replace=%0b mreq=%0b way=%0d expected 1 0 0 0",
                 req_ready, replace, mem_req_valid, way);
      end
      @(negedge clk);
      reset = 1'b1; mem_resp_valid = 1;
      @(negedge clk);
      mem_resp_valid = 0;
      checks++;
      if ({replace, req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL late_resp: replace=%0b ready=%0b expected 0 1", replace, req_ready);
      end
      return;
    end
    @(negedge clk);
    mem_resp_valid = 1;
    @(negedge clk);
    mem_resp_valid = 0;
    checks++;
    if ({replace, way, cache_tag, cache_index} !== {1'b1, exp_v, tag, idx}) begin
      errors++;
      $display("FAIL fill: replace=%0b way=%0d tag=%h idx=%0d, expected 1 %0d %h %0d",
               replace, way, cache_tag, cache_index, exp_v, tag, idx);
    end
    @(negedge clk);
    checks++;
    if ({replace, way, req_ready} !== {1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL post_fill: replace=%0b way=%0d ready=%0b, expected 0 0 1", replace, way, req_ready);
    end
  endtask

  task automatic test_first_miss();
    do_miss(24'h123456, 3'd2, 8'h00, 3'd0, 0, 0, 0);
  endtask

  task automatic test_plru_victim();
    do_miss(24'h000501, 3'd5, 8'hFF, 3'd0, 0, 0, 0);
    touch(3'd5, 3'd0);
    do_miss(24'h000502, 3'd5, 8'hFF, 3'd4, 1, 0, 0);
    touch(3'd5, 3'd0); touch(3'd5, 3'd4); touch(3'd5, 3'd2); touch(3'd5, 3'd6);
    do_miss(24'h000503, 3'd5, 8'hFF, 3'd1, 0, 0, 0);
  endtask

  task automatic test_invalid_priority();
    touch(3'd5, 3'd3);
    do_miss(24'h0F7F7F, 3'd5, 8'hF7, 3'd3, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] ways [3];
    ways[0] = 3'd5; ways[1] = 3'd5; ways[2] = 3'd1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: req_ready=%0b expected 1", i, req_ready);
      end
      req_valid = 1; hit = 1; hit_way = ways[i]; req_index = 3'd6;
      sb.push_back({1'b1, ways[i]});
      @(negedge clk);
    end
    req_valid = 0; hit = 0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_end: req_ready=%0b expected 1", req_ready);
    end
  endtask

  task automatic test_mem_stall();
    do_miss(24'hBEEF01, 3'd1, 8'h01, 3'd1, 4, 1, 0);
  endtask

  task automatic test_reset_wait();
    touch(3'd4, 3'd0);
    do_miss(24'hDEAD04, 3'd4, 8'hFF, 3'd4, 1, 0, 1);
    // PLRU cleared by reset: victim falls back to way 0.
    do_miss(24'hDEAD05, 3'd4, 8'hFF, 3'd0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_plru_victim();
    test_invalid_priority();
    test_back_to_back();
    test_mem_stall();
    test_reset_wait();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
